// File: rtl/i2s_tx_frame_fifo_if.sv
// Host push and transmitter request signals of the I2S TX frame FIFO.
// master: the host / i2s_top_tx side, slave: the FIFO.
interface i2s_tx_frame_fifo_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] s_left_i;
    logic [WORD_WIDTH-1:0] s_right_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic                  req_i;
    logic                  lr_chnl_i;
    logic [WORD_WIDTH-1:0] data_o;

    modport master (
        output s_left_i, s_right_i, s_valid_i, req_i, lr_chnl_i,
        input  s_ready_o, data_o
    );

    modport slave (
        input  s_left_i, s_right_i, s_valid_i, req_i, lr_chnl_i,
        output s_ready_o, data_o
    );
endinterface

// File: rtl/i2s_tx_frame_fifo.sv
// Stereo frame FIFO feeding i2s_top_tx. Stores left/right pairs as whole
// frames and answers per-word channel requests one clock later, never
// letting playback start on a right word.
// Optional feature: define I2S_TX_FIFO_UNDERRUN_HOLD_EN to repeat the last
// sample sent on a channel instead of sending silence on underrun/slip.
//
// left_sent | meaning
// 0         | head frame untouched, next word must be a left word
// 1         | head.left already sent, a right request pops the frame
module i2s_tx_frame_fifo #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    i2s_tx_frame_fifo_if.slave    bus,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  underrun_o,
    input  logic                  clr_underrun_i
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [2*WORD_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]     wr_ptr;
    logic [DEPTH_LOG2:0]     rd_ptr;
    logic                    left_sent;
    logic                    push;
    logic [WORD_WIDTH-1:0]   head_left;
    logic [WORD_WIDTH-1:0]   head_right;
    logic [WORD_WIDTH-1:0]   fill_left;
    logic [WORD_WIDTH-1:0]   fill_right;

    assign level_o = wr_ptr - rd_ptr;
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Ready is forced low during reset so a host cannot push into a FIFO
    // whose pointers are being cleared.
    assign bus.s_ready_o = !full_o && rst_ni;
    assign push          = bus.s_valid_i && bus.s_ready_o;

    assign head_left  = mem[rd_ptr[DEPTH_LOG2-1:0]][2*WORD_WIDTH-1:WORD_WIDTH];
    assign head_right = mem[rd_ptr[DEPTH_LOG2-1:0]][WORD_WIDTH-1:0];

`ifdef I2S_TX_FIFO_UNDERRUN_HOLD_EN
    logic [WORD_WIDTH-1:0] hold_left;
    logic [WORD_WIDTH-1:0] hold_right;

    assign fill_left  = hold_left;
    assign fill_right = hold_right;

    // Remember the last sample actually sent on each channel.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_left  <= '0;
            hold_right <= '0;
        end else if (bus.req_i) begin
            if (!bus.lr_chnl_i && !empty_o) begin
                hold_left <= head_left;
            end else if (bus.lr_chnl_i && left_sent) begin
                hold_right <= head_right;
            end
        end
    end
`else
    assign fill_left  = '0;
    assign fill_right = '0;
`endif

    // Frame array write; contents intentionally survive reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.s_left_i, bus.s_right_i};
        end
    end

    // Pointers, frame sequencing, output word and sticky underrun flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            left_sent  <= 1'b0;
            bus.data_o <= '0;
            underrun_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (clr_underrun_i) begin
                underrun_o <= 1'b0;
            end
            if (bus.req_i) begin
                if (!bus.lr_chnl_i) begin
                    if (!empty_o) begin
                        bus.data_o <= head_left;
                        left_sent  <= 1'b1;
                    end else begin
                        bus.data_o <= fill_left;
                        underrun_o <= 1'b1;
                    end
                end else if (left_sent) begin
                    bus.data_o <= head_right;
                    rd_ptr     <= rd_ptr + 1'b1;
                    left_sent  <= 1'b0;
                end else begin
                    // Right word with no left sent: pad without popping so
                    // the frame stays aligned to the next left word.
                    bus.data_o <= fill_right;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_frame_fifo.sv
// Directed bench for i2s_tx_frame_fifo, default build (silence fill).
module tb_i2s_tx_frame_fifo;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clr_underrun_i;
    logic [3:0] level_o;
    logic       empty_o;
    logic       full_o;
    logic       underrun_o;

    int total = 0;
    int bad   = 0;

    i2s_tx_frame_fifo_if #(.WORD_WIDTH(16)) bus ();

    i2s_tx_frame_fifo #(.WORD_WIDTH(16), .DEPTH_LOG2(3)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .level_o        (level_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .underrun_o     (underrun_o),
        .clr_underrun_i (clr_underrun_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one active edge, then settle on the falling edge for sampling/driving
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bus.s_valid_i = 1'b1;
        bus.s_left_i  = l;
        bus.s_right_i = r;
        step();
        bus.s_valid_i = 1'b0;
    endtask

    task automatic req(input logic lr);
        bus.req_i     = 1'b1;
        bus.lr_chnl_i = lr;
        step();
        bus.req_i     = 1'b0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        clr_underrun_i = 1'b0;
        bus.s_valid_i  = 1'b0;
        bus.s_left_i   = '0;
        bus.s_right_i  = '0;
        bus.req_i      = 1'b0;
        bus.lr_chnl_i  = 1'b0;
        step();
        step();
        chk("rst_data", bus.data_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_ready", bus.s_ready_o, 0);
        rst_ni = 1'b1;
        step();
        chk("ready_after_rst", bus.s_ready_o, 1);

        // basic order
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        chk("basic_level2", level_o, 2);
        req(1'b0);
        chk("basic_d0", bus.data_o, 16'h1111);
        chk("basic_lvl_after_left", level_o, 2);
        req(1'b1);
        chk("basic_d1", bus.data_o, 16'h2222);
        chk("basic_level1", level_o, 1);
        req(1'b0);
        chk("basic_d2", bus.data_o, 16'h3333);
        req(1'b1);
        chk("basic_d3", bus.data_o, 16'h4444);
        chk("basic_level0", level_o, 0);
        chk("basic_empty", empty_o, 1);
        step();
        chk("basic_hold", bus.data_o, 16'h4444);
        chk("basic_no_underrun", underrun_o, 0);

        // fill to full
        for (int i = 0; i < 8; i++) push({8'h10, 8'(i)}, {8'h20, 8'(i)});
        chk("full_flag", full_o, 1);
        chk("full_ready", bus.s_ready_o, 0);
        chk("full_level", level_o, 8);
        // host keeps offering frame 8 while one frame is popped
        bus.s_valid_i = 1'b1;
        bus.s_left_i  = 16'h1008;
        bus.s_right_i = 16'h2008;
        req(1'b0);
        chk("full_pop_left", bus.data_o, 16'h1000);
        chk("full_no_push", level_o, 8);
        req(1'b1);
        chk("full_pop_right", bus.data_o, 16'h2000);
        chk("pop_level7", level_o, 7);
        chk("pop_ready", bus.s_ready_o, 1);
        step();
        bus.s_valid_i = 1'b0;
        chk("refill_level8", level_o, 8);
        chk("refill_full", full_o, 1);
        for (int i = 1; i <= 8; i++) begin
            req(1'b0);
            chk("wrap_left", bus.data_o, {16'h0, 8'h10, 8'(i)});
            req(1'b1);
            chk("wrap_right", bus.data_o, {16'h0, 8'h20, 8'(i)});
        end
        chk("wrap_empty", empty_o, 1);
        for (int i = 9; i <= 15; i++) push({8'h30, 8'(i)}, {8'h40, 8'(i)});
        chk("wrap2_level", level_o, 7);
        for (int i = 9; i <= 15; i++) begin
            req(1'b0);
            chk("wrap2_left", bus.data_o, {16'h0, 8'h30, 8'(i)});
            req(1'b1);
            chk("wrap2_right", bus.data_o, {16'h0, 8'h40, 8'(i)});
        end
        chk("wrap2_empty", empty_o, 1);
        chk("wrap2_no_underrun", underrun_o, 0);

        // underrun
        req(1'b0);
        chk("ur_data", bus.data_o, 0);
        chk("ur_flag", underrun_o, 1);
        step();
        chk("ur_sticky", underrun_o, 1);
        clr_underrun_i = 1'b1;
        step();
        clr_underrun_i = 1'b0;
        chk("ur_cleared", underrun_o, 0);
        clr_underrun_i = 1'b1;
        req(1'b0);
        clr_underrun_i = 1'b0;
        chk("ur_set_wins", underrun_o, 1);
        chk("ur_set_wins_data", bus.data_o, 0);
        clr_underrun_i = 1'b1;
        step();
        clr_underrun_i = 1'b0;
        chk("ur_cleared2", underrun_o, 0);

        // push and left request in the same cycle into an empty FIFO
        bus.s_valid_i = 1'b1;
        bus.s_left_i  = 16'h5555;
        bus.s_right_i = 16'h6666;
        req(1'b0);
        bus.s_valid_i = 1'b0;
        chk("same_cycle_ur", underrun_o, 1);
        chk("same_cycle_data", bus.data_o, 0);
        chk("same_cycle_level", level_o, 1);
        req(1'b0);
        chk("same_cycle_next_l", bus.data_o, 16'h5555);
        req(1'b1);
        chk("same_cycle_next_r", bus.data_o, 16'h6666);
        clr_underrun_i = 1'b1;
        step();
        clr_underrun_i = 1'b0;

        // slip on a right request
        push(16'hAAAA, 16'hBBBB);
        req(1'b1);
        chk("slip_data", bus.data_o, 0);
        chk("slip_level", level_o, 1);
        chk("slip_no_underrun", underrun_o, 0);
        req(1'b0);
        chk("slip_left", bus.data_o, 16'hAAAA);
        req(1'b1);
        chk("slip_right", bus.data_o, 16'hBBBB);
        chk("slip_level0", level_o, 0);

        // repeated left request does not pop
        push(16'hCCCC, 16'hDDDD);
        req(1'b0);
        req(1'b0);
        chk("rep_left", bus.data_o, 16'hCCCC);
        chk("rep_level", level_o, 1);
        req(1'b1);
        chk("rep_right", bus.data_o, 16'hDDDD);

        // reset mid-operation
        req(1'b0);
        chk("pre_rst_ur", underrun_o, 1);
        push(16'h0101, 16'h0202);
        push(16'h0303, 16'h0404);
        push(16'h0505, 16'h0606);
        req(1'b0);
        chk("pre_rst_left", bus.data_o, 16'h0101);
        chk("pre_rst_level", level_o, 3);
        rst_ni = 1'b0;
        step();
        chk("mid_rst_data", bus.data_o, 0);
        chk("mid_rst_level", level_o, 0);
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_full", full_o, 0);
        chk("mid_rst_underrun", underrun_o, 0);
        chk("mid_rst_ready", bus.s_ready_o, 0);
        rst_ni = 1'b1;
        req(1'b1);
        chk("post_rst_right", bus.data_o, 0);
        chk("post_rst_right_ur", underrun_o, 0);
        req(1'b0);
        chk("post_rst_left", bus.data_o, 0);
        chk("post_rst_ur", underrun_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
